// File: rtl/bus_reg_seq.sv
// bus_reg_seq: a chain of NREG registers sharing one internal bus.
// A sequencer moves one word per clock, tail first, so the chain behaves as a
// bus-sequenced delay/staging line between a ready/valid producer and consumer.
// In rotate mode the tail word is parked in a hold register and fed back into
// the head, so the chain recirculates instead of draining.
module bus_reg_seq #(
    parameter int WIDTH = 4,
    parameter int NREG  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      data_out,
    output logic [1:0]            state,
    output logic [NREG*WIDTH-1:0] regs
);

    // The MOVE pointer only ever holds values 1..NREG-1.
    localparam int PTR_W = (NREG > 2) ? $clog2(NREG) : 1;
    localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(NREG - 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        MOVE  = 2'd2,
        LOAD  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptrNext;
    logic             r_modeLatched;
    logic             w_modeNext;

    logic [WIDTH-1:0] r_regs [NREG];
    logic [NREG-1:0]  r_vld;
    logic [WIDTH-1:0] r_hold;
    logic             r_holdVld;
    logic [WIDTH-1:0] r_dataOut;
    logic             r_outValid;

    logic [WIDTH-1:0] w_bus;
    logic             w_busVld;
    logic [PTR_W-1:0] w_srcIdx;
    logic [WIDTH-1:0] w_tail;
    logic             w_tailVld;
    logic             w_stall;
    logic             w_drainLoad;
    logic             w_drainHold;
    logic             w_consume;

    assign w_srcIdx  = r_ptr - PTR_ONE;
    assign w_tail    = r_regs[NREG-1];
    assign w_tailVld = r_vld[NREG-1];

    // A shift-mode DRAIN must wait while the previous output word is still
    // unconsumed; otherwise it would overwrite data_out and lose a word.
    assign w_stall     = (r_state == DRAIN) && !r_modeLatched && w_tailVld
                         && r_outValid && !out_ready;
    assign w_drainLoad = (r_state == DRAIN) && !r_modeLatched && w_tailVld && !w_stall;
    assign w_drainHold = (r_state == DRAIN) && r_modeLatched;
    assign w_consume   = r_outValid && out_ready;

    // State register: FSM state, MOVE pointer and the per-round mode latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ptr         <= PTR_TOP;
            r_modeLatched <= 1'b0;
        end else begin
            r_state       <= w_stateNext;
            r_ptr         <= w_ptrNext;
            r_modeLatched <= w_modeNext;
        end
    end

    // Next-state logic: mode is captured only when a round starts, en only in IDLE and at LOAD.
    always_comb begin
        w_stateNext = r_state;
        w_ptrNext   = r_ptr;
        w_modeNext  = r_modeLatched;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_stateNext = DRAIN;
                    w_modeNext  = mode;
                end
            end
            DRAIN: begin
                if (!w_stall) begin
                    w_stateNext = MOVE;
                    w_ptrNext   = PTR_TOP;
                end
            end
            MOVE: begin
                if (r_ptr == PTR_ONE) begin
                    w_stateNext = LOAD;
                end else begin
                    w_ptrNext = r_ptr - PTR_ONE;
                end
            end
            LOAD: begin
                if (en) begin
                    w_stateNext = DRAIN;
                    w_modeNext  = mode;
                end else begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Output decode: selects the single bus source for the current state and drives in_ready.
    always_comb begin
        in_ready = 1'b0;
        w_bus    = '0;
        w_busVld = 1'b0;
        case (r_state)
            DRAIN: begin
                w_bus    = w_tail;
                w_busVld = w_tailVld;
            end
            MOVE: begin
                w_bus    = r_regs[w_srcIdx];
                w_busVld = r_vld[w_srcIdx];
            end
            LOAD: begin
                if (r_modeLatched) begin
                    w_bus    = r_hold;
                    w_busVld = r_holdVld;
                end else begin
                    in_ready = 1'b1;
                    w_bus    = data_in;
                    w_busVld = in_valid;
                end
            end
            default: begin
                w_bus    = '0;
                w_busVld = 1'b0;
            end
        endcase
    end

    // Chain registers: MOVE writes Reg[k] from the bus, LOAD writes Reg[0]; a stall freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                r_regs[k] <= '0;
            end
            r_vld <= '0;
        end else if (r_state == MOVE) begin
            r_regs[r_ptr] <= w_bus;
            r_vld[r_ptr]  <= w_busVld;
        end else if (r_state == LOAD) begin
            r_regs[0] <= w_bus;
            r_vld[0]  <= w_busVld;
        end
    end

    // Rotate-hold register: parks the tail word during a rotate-mode DRAIN until LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold    <= '0;
            r_holdVld <= 1'b0;
        end else if (w_drainHold) begin
            r_hold    <= w_bus;
            r_holdVld <= w_busVld;
        end
    end

    // Output register: a consumed word clears out_valid, but a new DRAIN word takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dataOut  <= '0;
            r_outValid <= 1'b0;
        end else if (w_drainLoad) begin
            r_dataOut  <= w_bus;
            r_outValid <= 1'b1;
        end else if (w_consume) begin
            r_outValid <= 1'b0;
        end
    end

    assign data_out  = r_dataOut;
    assign out_valid = r_outValid;
    assign state     = r_state;

    for (genvar k = 0; k < NREG; k++) begin : g_tap
        assign regs[k*WIDTH +: WIDTH] = r_regs[k];
    end

endmodule

// File: tb/tb_bus_reg_seq.sv
// tb_bus_reg_seq: scenario-driven bench for bus_reg_seq (WIDTH=4, NREG=3).
// Words the bench hands to the block are queued as expected output; words the
// consumer side takes are queued as observed output and matched in order.
module tb_bus_reg_seq;

    localparam int WIDTH = 4;
    localparam int NREG  = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic                  mode;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      data_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      data_out;
    logic [1:0]            state;
    logic [NREG*WIDTH-1:0] regs;

    int passCnt  = 0;
    int totalCnt = 0;
    int stepNo   = 0;
    logic lastAccept;
    logic lastHs;
    logic [WIDTH-1:0] expQ [$];
    logic [WIDTH-1:0] obsQ [$];

    bus_reg_seq #(.WIDTH(WIDTH), .NREG(NREG)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .state     (state),
        .regs      (regs)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs on the falling edge, then record what the next rising edge will transfer.
    task automatic applyStimulus(input logic iRst, input logic iEn, input logic iMode,
                                 input logic iValid, input logic [WIDTH-1:0] iData,
                                 input logic iOutReady);
        @(negedge clk);
        rst       = iRst;
        en        = iEn;
        mode      = iMode;
        in_valid  = iValid;
        data_in   = iData;
        out_ready = iOutReady;
        #1;
        stepNo++;
        lastAccept = !iRst && in_ready && iValid;
        lastHs     = !iRst && out_valid && iOutReady;
        if (lastAccept) expQ.push_back(iData);
        if (lastHs) obsQ.push_back(data_out);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        totalCnt++;
        if (state !== 2'd0) $display("[TB] FAIL reset_state: got %0d, want 0", state); else passCnt++;
        totalCnt++;
        if (regs !== 12'h000) $display("[TB] FAIL reset_regs: got %h, want 000", regs); else passCnt++;
        totalCnt++;
        if (data_out !== 4'd0) $display("[TB] FAIL reset_data_out: got %0d, want 0", data_out); else passCnt++;
        totalCnt++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b, want 0", out_valid); else passCnt++;
        totalCnt++;
        if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b, want 0", in_ready); else passCnt++;
        expQ.delete();
        obsQ.delete();
    endtask

    task automatic test_single();
        logic [WIDTH-1:0] expWord, obsWord;
        int acceptStep, seenStep;
        bit reached;
        acceptStep = -1;
        seenStep   = -1;
        reached    = 1'b0;
        for (int i = 0; i < 20 && acceptStep < 0; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b1);
            if (lastAccept) acceptStep = stepNo;
        end
        totalCnt++;
        if (acceptStep < 0) $display("[TB] FAIL single_accept: word never accepted, want accept at first LOAD"); else passCnt++;
        for (int i = 0; i < 20 && seenStep < 0; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
            if (stepNo == acceptStep + 1) begin
                totalCnt++;
                if (regs[3:0] !== 4'd9) $display("[TB] FAIL single_reg0: got %0d, want 9", regs[3:0]); else passCnt++;
            end
            if (stepNo == acceptStep + 4) begin
                totalCnt++;
                if (regs[7:4] !== 4'd9) $display("[TB] FAIL single_reg1: got %0d, want 9", regs[7:4]); else passCnt++;
            end
            if (stepNo == acceptStep + 7) begin
                totalCnt++;
                if (regs[11:8] !== 4'd9) $display("[TB] FAIL single_reg2: got %0d, want 9", regs[11:8]); else passCnt++;
            end
            if (out_valid === 1'b1) seenStep = stepNo;
        end
        // out_valid visible one half-cycle after the edge that is 9 clocks past the accept edge
        totalCnt++;
        if (seenStep - acceptStep != 10)
            $display("[TB] FAIL single_latency: got %0d clocks, want 9", seenStep - acceptStep - 1);
        else passCnt++;
        totalCnt++;
        if (data_out !== 4'd9) $display("[TB] FAIL single_data: got %0d, want 9", data_out); else passCnt++;
        for (int i = 0; i < 12 && !reached; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
            if (state === 2'd0) reached = 1'b1;
        end
        totalCnt++;
        if (!reached) $display("[TB] FAIL single_idle: state %0d, want 0", state); else passCnt++;
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            expWord = expQ.pop_front();
            obsWord = obsQ.pop_front();
            totalCnt++;
            if (obsWord !== expWord) $display("[TB] FAIL single_word: got %0d, want %0d", obsWord, expWord); else passCnt++;
        end
        totalCnt++;
        if (expQ.size() != 0 || obsQ.size() != 0)
            $display("[TB] FAIL single_count: unmatched observed %0d, unmatched expected %0d, want 0/0", obsQ.size(), expQ.size());
        else passCnt++;
        expQ.delete();
        obsQ.delete();
    endtask

    task automatic test_stream();
        logic [WIDTH-1:0] words [4];
        logic [WIDTH-1:0] expWord, obsWord;
        int hsStep [3];
        int idx, hsCnt;
        bit reached;
        words[0] = 4'd9; words[1] = 4'd7; words[2] = 4'd8; words[3] = 4'd0;
        hsStep[0] = 0; hsStep[1] = 0; hsStep[2] = 0;
        idx = 0; hsCnt = 0; reached = 1'b0;
        for (int i = 0; i < 80 && hsCnt < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, (idx < 3), words[idx], 1'b1);
            if (lastAccept) idx++;
            if (lastHs) begin
                hsStep[hsCnt] = stepNo;
                hsCnt++;
            end
        end
        totalCnt++;
        if (hsCnt != 3) $display("[TB] FAIL stream_outputs: got %0d words, want 3", hsCnt); else passCnt++;
        totalCnt++;
        if (hsStep[1] - hsStep[0] != 4) $display("[TB] FAIL stream_gap01: got %0d clocks, want 4", hsStep[1] - hsStep[0]); else passCnt++;
        totalCnt++;
        if (hsStep[2] - hsStep[1] != 4) $display("[TB] FAIL stream_gap12: got %0d clocks, want 4", hsStep[2] - hsStep[1]); else passCnt++;
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 12 && !reached; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
            if (state === 2'd0) reached = 1'b1;
        end
        totalCnt++;
        if (!reached) $display("[TB] FAIL stream_idle: state %0d, want 0", state); else passCnt++;
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            expWord = expQ.pop_front();
            obsWord = obsQ.pop_front();
            totalCnt++;
            if (obsWord !== expWord) $display("[TB] FAIL stream_word: got %0d, want %0d", obsWord, expWord); else passCnt++;
        end
        totalCnt++;
        if (expQ.size() != 0 || obsQ.size() != 0)
            $display("[TB] FAIL stream_count: unmatched observed %0d, unmatched expected %0d, want 0/0", obsQ.size(), expQ.size());
        else passCnt++;
        expQ.delete();
        obsQ.delete();
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] words [3];
        logic [WIDTH-1:0] expWord, obsWord;
        logic [NREG*WIDTH-1:0] snap;
        int idx;
        bit stalled, prevDrain, reached;
        words[0] = 4'd9; words[1] = 4'd7; words[2] = 4'd0;
        idx = 0; stalled = 1'b0; prevDrain = 1'b0; reached = 1'b0;
        for (int i = 0; i < 60 && !stalled; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, (idx < 2), words[idx], 1'b0);
            if (lastAccept) idx++;
            if (state === 2'd1 && prevDrain) stalled = 1'b1;
            prevDrain = (state === 2'd1);
        end
        totalCnt++;
        if (!stalled) $display("[TB] FAIL bp_stall: no DRAIN hold seen, want stall"); else passCnt++;
        totalCnt++;
        if (data_out !== 4'd9) $display("[TB] FAIL bp_held_data: got %0d, want 9", data_out); else passCnt++;
        totalCnt++;
        if (out_valid !== 1'b1) $display("[TB] FAIL bp_held_valid: got %b, want 1", out_valid); else passCnt++;
        snap = regs;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
            totalCnt++;
            if (state !== 2'd1) $display("[TB] FAIL bp_state: got %0d, want 1", state); else passCnt++;
            totalCnt++;
            if (regs !== snap) $display("[TB] FAIL bp_frozen: got %h, want %h", regs, snap); else passCnt++;
        end
        totalCnt++;
        if (obsQ.size() != 0) $display("[TB] FAIL bp_no_consume: got %0d words, want 0", obsQ.size()); else passCnt++;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        totalCnt++;
        if (out_valid !== 1'b1 || data_out !== 4'd7)
            $display("[TB] FAIL bp_next_word: got valid=%b data=%0d, want valid=1 data=7", out_valid, data_out);
        else passCnt++;
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 12 && !reached; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
            if (state === 2'd0) reached = 1'b1;
        end
        totalCnt++;
        if (!reached) $display("[TB] FAIL bp_idle: state %0d, want 0", state); else passCnt++;
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            expWord = expQ.pop_front();
            obsWord = obsQ.pop_front();
            totalCnt++;
            if (obsWord !== expWord) $display("[TB] FAIL bp_word: got %0d, want %0d", obsWord, expWord); else passCnt++;
        end
        totalCnt++;
        if (expQ.size() != 0 || obsQ.size() != 0)
            $display("[TB] FAIL bp_count: unmatched observed %0d, unmatched expected %0d, want 0/0", obsQ.size(), expQ.size());
        else passCnt++;
        expQ.delete();
        obsQ.delete();
    endtask

    task automatic test_rotate();
        logic [WIDTH-1:0] words [4];
        int idx;
        words[0] = 4'd1; words[1] = 4'd2; words[2] = 4'd3; words[3] = 4'd0;
        idx = 0;
        // mode rises before the LOAD that accepts the third word, so the following round rotates
        for (int i = 0; i < 40 && idx < 3; i++) begin
            applyStimulus(1'b0, 1'b1, (idx == 2), (idx < 3), words[idx], 1'b1);
            if (lastAccept) idx++;
        end
        totalCnt++;
        if (idx != 3) $display("[TB] FAIL rot_fill: got %0d words, want 3", idx); else passCnt++;
        for (int i = 1; i <= 13; i++) begin
            applyStimulus(1'b0, (i < 12), 1'b1, 1'b0, 4'd0, 1'b1);
            totalCnt++;
            if (in_ready !== 1'b0) $display("[TB] FAIL rot_in_ready: step %0d got %b, want 0", i, in_ready); else passCnt++;
            totalCnt++;
            if (out_valid !== 1'b0) $display("[TB] FAIL rot_out_valid: step %0d got %b, want 0", i, out_valid); else passCnt++;
            if (i == 1) begin
                totalCnt++;
                if (regs !== 12'h123) $display("[TB] FAIL rot_start: got %h, want 123", regs); else passCnt++;
            end
            if (i == 5) begin
                totalCnt++;
                if (regs !== 12'h231) $display("[TB] FAIL rot_round1: got %h, want 231", regs); else passCnt++;
            end
            if (i == 13) begin
                totalCnt++;
                if (regs !== 12'h123) $display("[TB] FAIL rot_round3: got %h, want 123", regs); else passCnt++;
                totalCnt++;
                if (state !== 2'd0) $display("[TB] FAIL rot_idle: got %0d, want 0", state); else passCnt++;
            end
        end
        totalCnt++;
        if (obsQ.size() != 0) $display("[TB] FAIL rot_no_output: got %0d words, want 0", obsQ.size()); else passCnt++;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        expQ.delete();
        obsQ.delete();
    endtask

    task automatic test_en_drop();
        logic [1:0] expStates [5];
        logic [WIDTH-1:0] expWord, obsWord;
        int acceptStep;
        bit reached;
        expStates[0] = 2'd1; expStates[1] = 2'd2; expStates[2] = 2'd2;
        expStates[3] = 2'd3; expStates[4] = 2'd0;
        acceptStep = -1; reached = 1'b0;
        for (int i = 0; i < 20 && acceptStep < 0; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b1);
            if (lastAccept) acceptStep = stepNo;
        end
        totalCnt++;
        if (acceptStep < 0) $display("[TB] FAIL en_accept: word never accepted, want accept"); else passCnt++;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b0, (i == 1), 1'b0, 1'b0, 4'd0, 1'b1);
            totalCnt++;
            if (state !== expStates[i-1]) $display("[TB] FAIL en_round_state: step %0d got %0d, want %0d", i, state, expStates[i-1]); else passCnt++;
        end
        totalCnt++;
        if (regs !== 12'h050) $display("[TB] FAIL en_regs: got %h, want 050", regs); else passCnt++;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
            totalCnt++;
            if (state !== 2'd0 || regs !== 12'h050)
                $display("[TB] FAIL en_hold: got state=%0d regs=%h, want state=0 regs=050", state, regs);
            else passCnt++;
        end
        acceptStep = -1;
        for (int i = 0; i < 20 && acceptStep < 0; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b1);
            if (lastAccept) acceptStep = stepNo;
        end
        for (int i = 0; i < 60 && obsQ.size() < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 12 && !reached; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
            if (state === 2'd0) reached = 1'b1;
        end
        totalCnt++;
        if (!reached) $display("[TB] FAIL en_idle: state %0d, want 0", state); else passCnt++;
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            expWord = expQ.pop_front();
            obsWord = obsQ.pop_front();
            totalCnt++;
            if (obsWord !== expWord) $display("[TB] FAIL en_word: got %0d, want %0d", obsWord, expWord); else passCnt++;
        end
        totalCnt++;
        if (expQ.size() != 0 || obsQ.size() != 0)
            $display("[TB] FAIL en_count: unmatched observed %0d, unmatched expected %0d, want 0/0", obsQ.size(), expQ.size());
        else passCnt++;
        expQ.delete();
        obsQ.delete();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; in_valid = 1'b0; data_in = '0; out_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_rotate();
        test_en_drop();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
